sensor_frame_scheduler: RTL
===========================

# sensor_frame_scheduler

Sequencer for the three-channel PDM sensor measurement path. Opens a fixed gate window on the per-channel pulse counters by clearing them, then latches the three 16-bit counts at gate close. It then feeds the counts one byte at a time into the byte-wide UART transmitter as a framed packet. It sits between the `counter_new` instances and the `UART` block and owns their `rst_count` and `START`/`UARTDATA` controls.

## Interface
- `GATE_CYCLES`, default 100000: length of the measurement gate in CLK cycles; ≥1.
- `BYTE_GAP`, default 104200: idle CLK cycles after each UART start pulse, covering one 10-bit character at 9600 baud and 100 MHz; ≥1; counter is 17 bits.
- `HEADER`, default 8'hA5: first byte of every frame.
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST_N`  in  1  asynchronous active-low reset.
- `enable`  in  1  request measurement; sampled in IDLE and at frame end.
- `result1`, `result2`, `result3`  in  16 each  counter outputs, channels 1–3.
- `rst_count`  out  1  counter clear, shared by all three counters.
- `uart_data`  out  8  byte to the UART (`UARTDATA`).
- `uart_start`  out  1  single-cycle UART start strobe (`START`).
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  single-cycle pulse on the last cycle of a frame.

## Operation
- The FSM has six states: IDLE, CLEAR, GATE, LATCH, SEND, GAP.
- IDLE → CLEAR when `enable`=1.
- CLEAR lasts 1 cycle, with `rst_count`=1. It is followed by GATE.
- GATE lasts exactly `GATE_CYCLES` cycles, with `rst_count`=0. It is followed by LATCH.
- LATCH lasts 1 cycle. The shadow registers load `result1..3`, the byte index is reset to 0, and the next state is SEND.
- SEND lasts 1 cycle. `uart_start`=1 and `uart_data` takes the byte at the current index. The next state is GAP.
- GAP lasts `BYTE_GAP` cycles. On its last cycle:
  - If the index is not the final one, increment it and go to SEND.
  - If it is the final one, pulse `frame_done`. Go to CLEAR if `enable`=1, otherwise go to IDLE.
- Frame byte order:
  - `HEADER`
  - `result1[15:8]`, `result1[7:0]`
  - `result2[15:8]`, `result2[7:0]`
  - `result3[15:8]`, `result3[7:0]`
  - optional checksum (see Configuration).
- Frame content comes only from the shadow registers. Changes on `result*` after LATCH do not affect the frame in flight.
- Dropping `enable` mid-frame does not abort the frame. The current frame completes, then the FSM goes to IDLE.
- An `enable` pulse in a non-IDLE state is ignored unless it is present on the frame's final GAP cycle.

## Timing
- All outputs are registered and decoded from the current state.
- Reset value of every output: 0. `uart_data`=8'h00; shadow registers, index and timers are also 0.
- `RST_N` low at any point, mid-frame included:
  - The FSM goes to IDLE asynchronously and all outputs clear.
  - No partial frame resumes.
  - The next frame starts with `HEADER`.
- `uart_data` is valid from the SEND cycle and stays stable until the next SEND. After a frame it holds the last byte.
- `uart_start` is exactly one cycle wide. Consecutive start strobes are exactly `BYTE_GAP`+1 cycles apart.
- Latency from `enable` sampled high in IDLE to the first `uart_start`: `GATE_CYCLES`+3 cycles.
- Frame length from CLEAR to the end of the last GAP: 2 + `GATE_CYCLES` + N·(`BYTE_GAP`+1), where N = 8 with checksum, 7 without.
- With `enable` held high, CLEAR follows `frame_done` on the very next cycle.

## Configuration
- Macro `FRAME_CHECKSUM_EN`.
- Defined: N=8. The final byte is the XOR of the six data bytes; `HEADER` is excluded.
- Undefined: N=7. The frame ends after `result3[7:0]` and no checksum logic is built.

## Structure
- The shared package `sensor_pkg` holds:
  - the state enum
  - `FRAME_LEN`, derived from the macro
  - the default `HEADER` constant
  - the byte-index width.
- One sub-module, `frame_byte_mux`. It is purely combinational: it maps the byte index and shadow registers to the byte value and contains the checksum XOR.
- Timers, FSM and shadow registers stay in the top module.

## Test plan
All scenarios use `GATE_CYCLES`=10 and `BYTE_GAP`=4 unless noted.
1. Reset: `RST_N`=0, then release with `enable`=0. All outputs stay 0 and `busy`=0 for 50 cycles.
2. Single frame, checksum on:
   - Stimulus: a 1-cycle `enable` pulse, with `result1`=16'h1234, `result2`=16'hABCD, `result3`=16'h0001.
   - Required bytes: A5, 12, 34, AB, CD, 00, 01, 41.
   - `rst_count` is high for exactly 1 cycle.
   - The first `uart_start` comes 13 cycles after `enable`, and strobes are 5 cycles apart.
   - There is one `frame_done` pulse, 52 cycles after CLEAR begins.
3. Latch isolation: change all `result*` to 16'hFFFF on the cycle after LATCH. The frame still carries the values from scenario 2.
4. Continuous mode: hold `enable`=1. `rst_count` rises on the cycle after each `frame_done`, and three consecutive frames are bit-identical for constant inputs.
5. Reset mid-frame:
   - Assert `RST_N` low during GAP after the 3rd byte.
   - Outputs clear immediately and no further strobes occur.
   - After re-enable, the first byte is A5.
6. Macro undefined: scenario 2 yields 7 bytes ending in 01, and `frame_done` comes 47 cycles after CLEAR begins.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types and constants for the PDM sensor frame scheduler.
// FRAME_CHECKSUM_EN appends an XOR checksum byte to every frame.
package sensor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GATE,
    S_LATCH,
    S_SEND,
    S_GAP
  } state_t;

`ifdef FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = 8;
`else
  localparam int FRAME_LEN = 7;
`endif

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
  localparam int         IDX_W          = 3;

endpackage

// File: rtl/sensor_frame_scheduler_if.sv
// Bundle of counter controls, counter results and UART-side signals of the scheduler.
interface sensor_frame_scheduler_if;

  logic        enable;
  logic [15:0] result1;
  logic [15:0] result2;
  logic [15:0] result3;
  logic        rst_count;
  logic [7:0]  uart_data;
  logic        uart_start;
  logic        busy;
  logic        frame_done;

  modport master (
    output enable, result1, result2, result3,
    input  rst_count, uart_data, uart_start, busy, frame_done
  );

  modport slave (
    input  enable, result1, result2, result3,
    output rst_count, uart_data, uart_start, busy, frame_done
  );

endinterface

// File: rtl/frame_byte_mux.sv
// Selects the frame byte for a given index from the latched counts.
// FRAME_CHECKSUM_EN adds the XOR checksum of the six data bytes at the final index.
module frame_byte_mux
  import sensor_pkg::*;
#(
  parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [15:0]      shadow1,
  input  logic [15:0]      shadow2,
  input  logic [15:0]      shadow3,
  output logic [7:0]       frame_byte
);

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = shadow1[15:8] ^ shadow1[7:0] ^ shadow2[15:8] ^ shadow2[7:0]
                  ^ shadow3[15:8] ^ shadow3[7:0];
`endif

  always_comb begin
    frame_byte = 8'h00;
    case (idx)
      3'd0:    frame_byte = HEADER;
      3'd1:    frame_byte = shadow1[15:8];
      3'd2:    frame_byte = shadow1[7:0];
      3'd3:    frame_byte = shadow2[15:8];
      3'd4:    frame_byte = shadow2[7:0];
      3'd5:    frame_byte = shadow3[15:8];
      3'd6:    frame_byte = shadow3[7:0];
`ifdef FRAME_CHECKSUM_EN
      3'd7:    frame_byte = checksum;
`endif
      default: frame_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/sensor_frame_scheduler.sv
// Gates the PDM pulse counters, latches their counts and streams them as a UART frame.
// FRAME_CHECKSUM_EN selects the 8-byte frame with trailing checksum.
module sensor_frame_scheduler
  import sensor_pkg::*;
#(
  parameter int         GATE_CYCLES = 100000,
  parameter int         BYTE_GAP    = 104200,
  parameter logic [7:0] HEADER      = DEFAULT_HEADER
) (
  input logic                     CLK,
  input logic                     RST_N,
  sensor_frame_scheduler_if.slave bus
);

  localparam int TIMER_MAX = (GATE_CYCLES > BYTE_GAP) ? GATE_CYCLES : BYTE_GAP;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] GATE_LAST = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(BYTE_GAP - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(FRAME_LEN - 1);

  state_t             state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [IDX_W-1:0]   index_reg, index_next;
  logic [15:0]        shadow1_reg, shadow1_next;
  logic [15:0]        shadow2_reg, shadow2_next;
  logic [15:0]        shadow3_reg, shadow3_next;

  logic       rst_count_reg, rst_count_next;
  logic [7:0] uart_data_reg, uart_data_next;
  logic       uart_start_reg, uart_start_next;
  logic       busy_reg, busy_next;
  logic       frame_done_reg, frame_done_next;
  logic [7:0] mux_byte;

  // Fed with next-cycle index/shadows so uart_data is already valid in the SEND cycle.
  frame_byte_mux #(.HEADER(HEADER)) u_byte_mux (
    .idx        (index_next),
    .shadow1    (shadow1_next),
    .shadow2    (shadow2_next),
    .shadow3    (shadow3_next),
    .frame_byte (mux_byte)
  );

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    index_next   = index_reg;
    shadow1_next = shadow1_reg;
    shadow2_next = shadow2_reg;
    shadow3_next = shadow3_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.enable) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        timer_next = '0;
        state_next = S_GATE;
      end
      S_GATE: begin
        if (timer_reg == GATE_LAST) begin
          timer_next = '0;
          state_next = S_LATCH;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      S_LATCH: begin
        shadow1_next = bus.result1;
        shadow2_next = bus.result2;
        shadow3_next = bus.result3;
        index_next   = '0;
        state_next   = S_SEND;
      end
      S_SEND: begin
        timer_next = '0;
        state_next = S_GAP;
      end
      S_GAP: begin
        if (timer_reg == GAP_LAST) begin
          timer_next = '0;
          if (index_reg == IDX_LAST) begin
            state_next = bus.enable ? S_CLEAR : S_IDLE;
          end else begin
            index_next = index_reg + 1'b1;
            state_next = S_SEND;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Outputs are decoded from the state being entered, then registered.
    rst_count_next  = (state_next == S_CLEAR);
    uart_start_next = (state_next == S_SEND);
    uart_data_next  = (state_next == S_SEND) ? mux_byte : uart_data_reg;
    busy_next       = (state_next != S_IDLE);
    frame_done_next = (state_next == S_GAP) && (timer_next == GAP_LAST)
                      && (index_next == IDX_LAST);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg      <= S_IDLE;
      timer_reg      <= '0;
      index_reg      <= '0;
      shadow1_reg    <= '0;
      shadow2_reg    <= '0;
      shadow3_reg    <= '0;
      rst_count_reg  <= 1'b0;
      uart_data_reg  <= 8'h00;
      uart_start_reg <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      index_reg      <= index_next;
      shadow1_reg    <= shadow1_next;
      shadow2_reg    <= shadow2_next;
      shadow3_reg    <= shadow3_next;
      rst_count_reg  <= rst_count_next;
      uart_data_reg  <= uart_data_next;
      uart_start_reg <= uart_start_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign bus.rst_count  = rst_count_reg;
  assign bus.uart_data  = uart_data_reg;
  assign bus.uart_start = uart_start_reg;
  assign bus.busy       = busy_reg;
  assign bus.frame_done = frame_done_reg;

endmodule
